test_seq: RTL and testbench
===========================

TEST_SEQ -- requirements
Module: test_seq

Interface
REQ-001 Parameter NUM_TESTS, default 6: number of directed tests run per sequence (1..256).
REQ-002 Parameter DATA_W, default 32: width of the core result word and the expected-value word.
REQ-003 Parameter RST_CYCLES, default 10: number of cycles core_rst_n is held low before each test.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000: cycle limit for one test to raise test_done.
REQ-005 Port list, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a sequence when the block is idle.
- core_rst_n  out  1  active-low reset driven to the core under test.
- test_idx  out  8  index of the current test.
- test_done  in  1  core signals that the current test has ended.
- result  in  DATA_W  core result word, valid while test_done=1.
- exp_addr  out  8  expected-value ROM address.
- exp_data  in  DATA_W  ROM data, valid one cycle after exp_addr.
- busy  out  1  a sequence is in progress.
- finished  out  1  sticky; sequence complete.
- pass_cnt  out  9  number of passing tests.
- fail_cnt  out  9  number of failing tests.
- first_fail  out  8  index of the first failing test; 8'hFF when there is none.

Function
REQ-006 FSM states: IDLE, CORE_RST, RUN, FETCH, CHECK, ADVANCE, DONE.
REQ-007 IDLE: start=1 clears the counters and finished, sets test_idx=0, and moves to CORE_RST.
REQ-008 start is ignored in every state except IDLE and DONE.
REQ-009 CORE_RST: core_rst_n=0 for exactly RST_CYCLES cycles, then the FSM moves to RUN; core_rst_n=1 in all other states.
REQ-010 RUN: a timeout counter increments each cycle.
- test_done=1 captures result, drives exp_addr=test_idx, and moves to FETCH.
- The counter reaching TIMEOUT_CYCLES-1 without test_done records a fail with no compare, then moves to ADVANCE.
REQ-011 FETCH: one wait cycle for ROM latency; the FSM moves to CHECK.
REQ-012 CHECK: the captured result is compared with exp_data over the full DATA_W width.
- Equal: pass_cnt increments.
- Not equal: fail_cnt increments.
REQ-013 first_fail latches test_idx only on the first fail of a sequence, whether from a compare mismatch or a timeout.
REQ-014 ADVANCE, normal case: test_idx increments and the FSM returns to CORE_RST.
REQ-015 ADVANCE, last test (test_idx=NUM_TESTS-1): the FSM moves to DONE and test_idx holds.
REQ-016 DONE: finished=1 and busy=0; start=1 restarts the sequence exactly as from IDLE.
REQ-017 busy=1 in CORE_RST, RUN, FETCH, CHECK and ADVANCE.
REQ-018 In every sequence, pass_cnt+fail_cnt equals the number of tests completed, and never exceeds NUM_TESTS.
REQ-019 test_done while the FSM is not in RUN is ignored.
REQ-020 Total latency per test is RST_CYCLES + run cycles + 3 cycles.

Reset
REQ-021 rst=1 at any clock edge forces the following values, including mid-sequence:
- FSM to IDLE.
- core_rst_n=0.
- test_idx=0, exp_addr=0.
- busy=0, finished=0.
- pass_cnt=0, fail_cnt=0.
- first_fail=8'hFF.
- Timeout counter and RST counter = 0.
REQ-022 In IDLE after reset, core_rst_n stays 0 until the first CORE_RST phase completes.

Configuration
REQ-023 Macro TEST_SEQ_STOP_ON_FAIL_EN.
- Defined: the first fail moves the FSM from CHECK or RUN directly to DONE, with finished=1 and test_idx held at the failing test.
- Undefined: every test runs regardless of fails.

Verification
REQ-024 NUM_TESTS=3, RST_CYCLES=10; core returns 5, 7, 9 and the ROM holds 5, 7, 9 -> pass_cnt=3, fail_cnt=0, first_fail=FF, finished=1.
REQ-025 ROM holds 5, 8, 9 and the core returns 5, 7, 9 -> pass_cnt=2, fail_cnt=1, first_fail=1.
- With TEST_SEQ_STOP_ON_FAIL_EN defined: pass_cnt=1, fail_cnt=1, test_idx=1.
REQ-026 TIMEOUT_CYCLES=20; test_done never asserts for test 0 -> fail recorded 20 cycles after RUN entry, first_fail=0, test_idx advances to 1.
REQ-027 start pulse, then core_rst_n is observed low for exactly 10 cycles before each test; a second start pulse during RUN -> no effect on test_idx or the counters.
REQ-028 rst=1 asserted during CHECK of test 1 -> next cycle: FSM in IDLE, all counters 0, first_fail=FF, core_rst_n=0.
REQ-029 result differs from exp_data only in bit DATA_W-1 (for example 32'h80000005 vs 32'h00000005) -> fail recorded.

Source files
------------

// File: rtl/test_seq.sv
// Test sequencer: resets the core, runs NUM_TESTS tests, checks each result against a 1-cycle-latency ROM.
// Optional feature macro TEST_SEQ_STOP_ON_FAIL_EN: the first failing test ends the sequence immediately.
module test_seq #(
  parameter int NUM_TESTS      = 6,
  parameter int DATA_W         = 32,
  parameter int RST_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              core_rst_n,
  output logic [7:0]        test_idx,
  input  logic              test_done,
  input  logic [DATA_W-1:0] result,
  output logic [7:0]        exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              finished,
  output logic [8:0]        pass_cnt,
  output logic [8:0]        fail_cnt,
  output logic [7:0]        first_fail
);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [TC_W-1:0] TO_LAST  = TC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      LAST_IDX = 8'(NUM_TESTS - 1);

  typedef enum logic [2:0] {IDLE, CORE_RST, RUN, FETCH, CHECK, ADVANCE, DONE} state_t;

  state_t            r_state;
  logic              r_core_rst_n;
  logic [7:0]        r_test_idx;
  logic [7:0]        r_exp_addr;
  logic              r_busy;
  logic              r_finished;
  logic [8:0]        r_pass_cnt;
  logic [8:0]        r_fail_cnt;
  logic [7:0]        r_first_fail;
  logic [RC_W-1:0]   r_rst_cnt;
  logic [TC_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_result;

  logic w_last;
  logic w_match;
  logic w_first;

  assign w_last  = (r_test_idx == LAST_IDX);
  assign w_match = (r_result == exp_data);
  // fail_cnt==0 marks the first fail, so index 8'hFF stays unambiguous
  assign w_first = (r_fail_cnt == 9'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_core_rst_n <= 1'b0;
      r_test_idx   <= 8'd0;
      r_exp_addr   <= 8'd0;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
      r_pass_cnt   <= 9'd0;
      r_fail_cnt   <= 9'd0;
      r_first_fail <= 8'hFF;
      r_rst_cnt    <= '0;
      r_to_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= CORE_RST;
            r_core_rst_n <= 1'b0;
            r_rst_cnt    <= '0;
            r_test_idx   <= 8'd0;
            r_pass_cnt   <= 9'd0;
            r_fail_cnt   <= 9'd0;
            r_first_fail <= 8'hFF;
            r_busy       <= 1'b1;
            r_finished   <= 1'b0;
          end
        end
        CORE_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            r_state      <= RUN;
            r_core_rst_n <= 1'b1;
            r_to_cnt     <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RC_W'(1);
          end
        end
        RUN: begin
          if (test_done) begin
            r_result   <= result;
            r_exp_addr <= r_test_idx;
            r_state    <= FETCH;
          end else if (r_to_cnt == TO_LAST) begin
            r_fail_cnt <= r_fail_cnt + 9'd1;
            if (w_first) r_first_fail <= r_test_idx;
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
`else
            r_state    <= ADVANCE;
`endif
          end else begin
            r_to_cnt <= r_to_cnt + TC_W'(1);
          end
        end
        FETCH: r_state <= CHECK;
        CHECK: begin
          if (w_match) begin
            r_pass_cnt <= r_pass_cnt + 9'd1;
            r_state    <= ADVANCE;
          end else begin
            r_fail_cnt <= r_fail_cnt + 9'd1;
            if (w_first) r_first_fail <= r_test_idx;
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
`else
            r_state    <= ADVANCE;
`endif
          end
        end
        ADVANCE: begin
          if (w_last) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
          end else begin
            r_test_idx   <= r_test_idx + 8'd1;
            r_state      <= CORE_RST;
            r_core_rst_n <= 1'b0;
            r_rst_cnt    <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_rst_n = r_core_rst_n;
  assign test_idx   = r_test_idx;
  assign exp_addr   = r_exp_addr;
  assign busy       = r_busy;
  assign finished   = r_finished;
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign first_fail = r_first_fail;
endmodule

// File: tb/tb_test_seq.sv
// Directed bench for test_seq: behavioural core and 1-cycle ROM, default build (stop-on-fail disabled).
module tb_test_seq;
  localparam int NT = 3, DW = 32, RC = 10, TO = 20, CORE_DLY = 2;

  logic          clk = 1'b0;
  logic          rst, start, core_rst_n, test_done;
  logic [7:0]    test_idx, exp_addr, first_fail;
  logic [DW-1:0] result, exp_data;
  logic          busy, finished;
  logic [8:0]    pass_cnt, fail_cnt;

  logic [31:0] rom      [4];
  logic [31:0] core_res [4];
  logic        core_hang[4];
  int          core_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  test_seq #(.NUM_TESTS(NT), .DATA_W(DW), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .core_rst_n(core_rst_n), .test_idx(test_idx),
    .test_done(test_done), .result(result), .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .finished(finished), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail(first_fail)
  );

  always @(posedge clk) exp_data <= rom[exp_addr[1:0]];

  // Core model: answers CORE_DLY cycles after its reset is released, unless told to hang
  always @(negedge clk) begin
    if (rst || !core_rst_n) begin
      core_cnt  = 0;
      test_done = 1'b0;
    end else begin
      test_done = (core_cnt == CORE_DLY) && !core_hang[test_idx[1:0]];
      result    = core_res[test_idx[1:0]];
      core_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_finished(input string tag);
    int k;
    k = 0;
    while (!finished && k < 1000) begin
      tick();
      k++;
    end
    check(tag, 32'(finished), 32'd1);
  endtask

  task automatic load(input logic [31:0] r0, r1, r2, c0, c1, c2);
    rom[0] = r0; rom[1] = r1; rom[2] = r2; rom[3] = '0;
    core_res[0] = c0; core_res[1] = c1; core_res[2] = c2; core_res[3] = '0;
  endtask

  initial begin
    int k, low;
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) core_hang[i] = 1'b0;
    load(5, 7, 9, 5, 7, 9);
    repeat (3) tick();

    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_test_idx",   32'(test_idx),   32'd0);
    check("rst_exp_addr",   32'(exp_addr),   32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_finished",   32'(finished),   32'd0);
    check("rst_pass_cnt",   32'(pass_cnt),   32'd0);
    check("rst_fail_cnt",   32'(fail_cnt),   32'd0);
    check("rst_first_fail", 32'(first_fail), 32'hFF);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_core_rst_n_low", 32'(core_rst_n), 32'd0);

    // All pass; core reset width per test, mid-run start ignored, total latency 3*(10+3+3)
    pulse_start();
    k = 0; low = 0;
    while (!finished && k < 1000) begin
      if (!core_rst_n) low++;
      else if (low != 0) begin
        check("core_rst_low_width", 32'(low), 32'(RC));
        low = 0;
      end
      if (k == 11) start = 1'b1;
      if (k == 12) begin
        start = 1'b0;
        check("midrun_start_idx",  32'(test_idx), 32'd0);
        check("midrun_start_pass", 32'(pass_cnt), 32'd0);
        check("midrun_start_busy", 32'(busy),     32'd1);
      end
      tick();
      k++;
    end
    check("allpass_latency",    32'(k),          32'd48);
    check("allpass_pass",       32'(pass_cnt),   32'd3);
    check("allpass_fail",       32'(fail_cnt),   32'd0);
    check("allpass_first_fail", 32'(first_fail), 32'hFF);
    check("allpass_busy",       32'(busy),       32'd0);
    check("allpass_idx_hold",   32'(test_idx),   32'd2);
    check("done_core_rst_n",    32'(core_rst_n), 32'd1);

    // ROM mismatch on test 1, restarted from DONE
    load(5, 8, 9, 5, 7, 9);
    pulse_start();
    check("restart_finished_clr", 32'(finished), 32'd0);
    check("restart_busy",         32'(busy),     32'd1);
    check("restart_pass_clr",     32'(pass_cnt), 32'd0);
    wait_finished("mis_finish");
    check("mis_pass",       32'(pass_cnt),   32'd2);
    check("mis_fail",       32'(fail_cnt),   32'd1);
    check("mis_first_fail", 32'(first_fail), 32'd1);

    // Only the MSB differs on test 0
    load(5, 7, 9, 32'h80000005, 7, 9);
    pulse_start();
    wait_finished("msb_finish");
    check("msb_pass",       32'(pass_cnt),   32'd2);
    check("msb_fail",       32'(fail_cnt),   32'd1);
    check("msb_first_fail", 32'(first_fail), 32'd0);

    // Test 0 hangs: fail exactly TO cycles after RUN entry
    load(5, 7, 9, 5, 7, 9);
    core_hang[0] = 1'b1;
    pulse_start();
    k = 0;
    while (!core_rst_n && k < 100) begin tick(); k++; end
    check("to_run_entry", 32'(core_rst_n), 32'd1);
    k = 0;
    while (fail_cnt == 9'd0 && k < 100) begin tick(); k++; end
    check("to_fail_delay", 32'(k),        32'(TO));
    check("to_idx_before", 32'(test_idx), 32'd0);
    tick();
    check("to_idx_adv",     32'(test_idx),   32'd1);
    check("to_first_fail",  32'(first_fail), 32'd0);
    check("to_pass_none",   32'(pass_cnt),   32'd0);
    wait_finished("to_finish");
    check("to_pass", 32'(pass_cnt), 32'd2);
    check("to_fail", 32'(fail_cnt), 32'd1);
    core_hang[0] = 1'b0;

    // Synchronous reset while test 1 sits in CHECK
    pulse_start();
    k = 0;
    while (!(test_idx == 8'd1 && test_done) && k < 200) begin tick(); k++; end
    check("rc_test_done_seen", 32'(test_done), 32'd1);
    tick();
    tick();
    check("rc_pass_before", 32'(pass_cnt), 32'd1);
    rst = 1'b1;
    tick();
    check("rc_core_rst_n",  32'(core_rst_n), 32'd0);
    check("rc_busy",        32'(busy),       32'd0);
    check("rc_pass",        32'(pass_cnt),   32'd0);
    check("rc_fail",        32'(fail_cnt),   32'd0);
    check("rc_first_fail",  32'(first_fail), 32'hFF);
    check("rc_idx",         32'(test_idx),   32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rc_stays_idle",  32'(busy),       32'd0);
    check("rc_no_finished", 32'(finished),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
